stoch_im2col_seq: RTL and testbench



---
 rtl/stoch_im2col_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_stoch_im2col_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_im2col_seq.sv
// Patch/sample sequencer for stochastic signed im2col: one beat per (patch, sample).
// Define STOCH_IM2COL_SEQ_PERF_EN to add the stall_cnt/beat_cnt counters.
module stoch_im2col_seq #(
    parameter int IM_HEIGHT   = 12,
    parameter int IM_WIDTH    = 12,
    parameter int KERNEL_H    = 3,
    parameter int KERNEL_W    = 3,
    parameter int PAD_H       = 2,
    parameter int PAD_W       = 2,
    parameter int STRIDE_H    = 1,
    parameter int STRIDE_W    = 1,
    parameter int NUM_SAMPLES = 256,
    localparam int OUT_H      = (IM_HEIGHT + 2*PAD_H - KERNEL_H) / STRIDE_H + 1,
    localparam int OUT_W      = (IM_WIDTH + 2*PAD_W - KERNEL_W) / STRIDE_W + 1,
    localparam int COL_HEIGHT = OUT_H * OUT_W,
    localparam int RW         = $clog2(IM_HEIGHT + 2*PAD_H) + 1,
    localparam int CW         = $clog2(IM_WIDTH + 2*PAD_W) + 1,
    localparam int IW         = (COL_HEIGHT > 1) ? $clog2(COL_HEIGHT) : 1,
    localparam int SW         = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [RW-1:0] win_row,
    output logic signed [CW-1:0] win_col,
    output logic [IW-1:0]        col_idx,
    output logic [SW-1:0]        sample_idx,
    output logic                 first_sample,
    output logic                 last_sample,
    output logic                 last,
    output logic                 pad_hit
`ifdef STOCH_IM2COL_SEQ_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          beat_cnt
`endif
);

    localparam int RCW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int CCW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [RCW-1:0]        R_MAX = RCW'(OUT_H - 1);
    localparam logic [CCW-1:0]        C_MAX = CCW'(OUT_W - 1);
    localparam logic [SW-1:0]         S_MAX = SW'(NUM_SAMPLES - 1);
    localparam logic signed [RW-1:0]  ROW0  = RW'(-PAD_H);
    localparam logic signed [CW-1:0]  COL0  = CW'(-PAD_W);
    localparam logic signed [RW-1:0]  STR_R = RW'(STRIDE_H);
    localparam logic signed [CW-1:0]  STR_C = CW'(STRIDE_W);
    localparam logic LSAMP0 = (NUM_SAMPLES == 1);
    localparam logic LAST0  = (COL_HEIGHT == 1) && (NUM_SAMPLES == 1);
    localparam logic PAD0   = (PAD_H > 0) || (PAD_W > 0) ||
                              (KERNEL_H - PAD_H > IM_HEIGHT) ||
                              (KERNEL_W - PAD_W > IM_WIDTH);

    if (OUT_H < 1 || OUT_W < 1 || IM_HEIGHT + 2*PAD_H < KERNEL_H ||
        IM_WIDTH + 2*PAD_W < KERNEL_W) begin : g_bad_cfg
        $error("stoch_im2col_seq: output map is empty");
    end

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e                state_q, state_d;
    logic [RCW-1:0]        r_q, r_d;
    logic [CCW-1:0]        c_q, c_d;
    logic [SW-1:0]         s_q, s_d;
    logic signed [RW-1:0]  win_row_q, win_row_d;
    logic signed [CW-1:0]  win_col_q, win_col_d;
    logic [IW-1:0]         col_idx_q, col_idx_d;
    logic                  first_q, first_d;
    logic                  lsamp_q, lsamp_d;
    logic                  last_q, last_d;
    logic                  pad_q, pad_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  fire;
    logic                  reload;

    function automatic logic pad_of(logic signed [RW-1:0] wr,
                                    logic signed [CW-1:0] wc);
        int r;
        int c;
        r = int'(wr);
        c = int'(wc);
        return (r < 0) || (c < 0) ||
               (r + KERNEL_H > IM_HEIGHT) || (c + KERNEL_W > IM_WIDTH);
    endfunction

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        s_d       = s_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        col_idx_d = col_idx_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        reload    = 1'b0;
        fire      = valid_q && out_ready;
        unique case (state_q)
            S_IDLE: begin
                // start coinciding with the done pulse is dropped
                if (start && !done_q) begin
                    state_d = S_RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    reload  = 1'b1;
                end else if (fire && last_q) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    reload  = 1'b1;
                end else if (fire) begin
                    if (s_q == S_MAX) begin
                        s_d       = '0;
                        col_idx_d = col_idx_q + 1'b1;
                        if (c_q == C_MAX) begin
                            c_d       = '0;
                            win_col_d = COL0;
                            r_d       = r_q + 1'b1;
                            win_row_d = win_row_q + STR_R;
                        end else begin
                            c_d       = c_q + 1'b1;
                            win_col_d = win_col_q + STR_C;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reload) begin
            r_d       = '0;
            c_d       = '0;
            s_d       = '0;
            win_row_d = ROW0;
            win_col_d = COL0;
            col_idx_d = '0;
        end
        first_d = (s_d == '0);
        lsamp_d = (s_d == S_MAX);
        last_d  = (r_d == R_MAX) && (c_d == C_MAX) && (s_d == S_MAX);
        pad_d   = pad_of(win_row_d, win_col_d);
    end

`ifdef STOCH_IM2COL_SEQ_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] beats_q, beats_d;

    always_comb begin
        stall_d = stall_q;
        beats_d = beats_q;
        if (state_q == S_IDLE && start && !done_q) begin
            stall_d = '0;
            beats_d = '0;
        end else if (state_q == S_RUN) begin
            if (valid_q && !out_ready && stall_q != '1)
                stall_d = stall_q + 1'b1;
            if (fire && !abort && beats_q != '1)
                beats_d = beats_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            beats_q <= '0;
        end else begin
            stall_q <= stall_d;
            beats_q <= beats_d;
        end
    end

    assign stall_cnt = stall_q;
    assign beat_cnt  = beats_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            s_q       <= '0;
            win_row_q <= ROW0;
            win_col_q <= COL0;
            col_idx_q <= '0;
            first_q   <= 1'b1;
            lsamp_q   <= LSAMP0;
            last_q    <= LAST0;
            pad_q     <= PAD0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            s_q       <= s_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            col_idx_q <= col_idx_d;
            first_q   <= first_d;
            lsamp_q   <= lsamp_d;
            last_q    <= last_d;
            pad_q     <= pad_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign out_valid    = valid_q;
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;
    assign col_idx      = col_idx_q;
    assign sample_idx   = s_q;
    assign first_sample = first_q;
    assign last_sample  = lsamp_q;
    assign last         = last_q;
    assign pad_hit      = pad_q;

endmodule

// File: tb/tb_stoch_im2col_seq.sv
// Bench for stoch_im2col_seq: three configurations driven from one directed
// sequence, beats checked against a queue of expected values from a small model.
module tb_stoch_im2col_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic st_v [3];
    logic ab   [3];
    logic rdy  [3];
    logic vld  [3];
    logic dn   [3];
    logic bsy  [3];
    logic fs   [3];
    logic ls   [3];
    logic la   [3];
    logic ph   [3];

    logic signed [3:0] wr_a, wc_a, wr_b, wc_b, wr_c, wc_c;
    logic [3:0] ci_a, ci_c;
    logic [1:0] ci_b;
    logic [0:0] si_a, si_b, si_c;
`ifdef STOCH_IM2COL_SEQ_PERF_EN
    logic [31:0] sc [3];
    logic [31:0] bc [3];
`endif

    int tests = 0;
    int fails = 0;
    logic [35:0] q [$];

    stoch_im2col_seq #(
        .IM_HEIGHT(4), .IM_WIDTH(4), .KERNEL_H(3), .KERNEL_W(3),
        .PAD_H(1), .PAD_W(1), .STRIDE_H(1), .STRIDE_W(1), .NUM_SAMPLES(2)
    ) u_a (
        .CLK(clk), .RST(rst), .start(st_v[0]), .abort(ab[0]),
        .busy(bsy[0]), .done(dn[0]), .out_valid(vld[0]), .out_ready(rdy[0]),
        .win_row(wr_a), .win_col(wc_a), .col_idx(ci_a), .sample_idx(si_a),
        .first_sample(fs[0]), .last_sample(ls[0]), .last(la[0]),
        .pad_hit(ph[0])
`ifdef STOCH_IM2COL_SEQ_PERF_EN
        , .stall_cnt(sc[0]), .beat_cnt(bc[0])
`endif
    );

    stoch_im2col_seq #(
        .IM_HEIGHT(5), .IM_WIDTH(5), .KERNEL_H(3), .KERNEL_W(3),
        .PAD_H(0), .PAD_W(0), .STRIDE_H(2), .STRIDE_W(2), .NUM_SAMPLES(2)
    ) u_b (
        .CLK(clk), .RST(rst), .start(st_v[1]), .abort(ab[1]),
        .busy(bsy[1]), .done(dn[1]), .out_valid(vld[1]), .out_ready(rdy[1]),
        .win_row(wr_b), .win_col(wc_b), .col_idx(ci_b), .sample_idx(si_b),
        .first_sample(fs[1]), .last_sample(ls[1]), .last(la[1]),
        .pad_hit(ph[1])
`ifdef STOCH_IM2COL_SEQ_PERF_EN
        , .stall_cnt(sc[1]), .beat_cnt(bc[1])
`endif
    );

    stoch_im2col_seq #(
        .IM_HEIGHT(4), .IM_WIDTH(4), .KERNEL_H(3), .KERNEL_W(3),
        .PAD_H(1), .PAD_W(1), .STRIDE_H(1), .STRIDE_W(1), .NUM_SAMPLES(1)
    ) u_c (
        .CLK(clk), .RST(rst), .start(st_v[2]), .abort(ab[2]),
        .busy(bsy[2]), .done(dn[2]), .out_valid(vld[2]), .out_ready(rdy[2]),
        .win_row(wr_c), .win_col(wc_c), .col_idx(ci_c), .sample_idx(si_c),
        .first_sample(fs[2]), .last_sample(ls[2]), .last(la[2]),
        .pad_hit(ph[2])
`ifdef STOCH_IM2COL_SEQ_PERF_EN
        , .stall_cnt(sc[2]), .beat_cnt(bc[2])
`endif
    );

    // beat layout: {win_row, win_col, col_idx, sample_idx, first, last_s, last, pad}
    function automatic logic [35:0] pack(int wr, int wc, int ci, int si,
                                         logic f, logic l, logic lt, logic p);
        logic [35:0] v;
        v = {wr[7:0], wc[7:0], ci[7:0], si[7:0], f, l, lt, p};
        return v;
    endfunction

    function automatic logic [35:0] obs_of(int sel);
        case (sel)
            0: return pack(int'(wr_a), int'(wc_a), int'(ci_a), int'(si_a),
                           fs[0], ls[0], la[0], ph[0]);
            1: return pack(int'(wr_b), int'(wc_b), int'(ci_b), int'(si_b),
                           fs[1], ls[1], la[1], ph[1]);
            default: return pack(int'(wr_c), int'(wc_c), int'(ci_c), int'(si_c),
                                 fs[2], ls[2], la[2], ph[2]);
        endcase
    endfunction

    function automatic void cfg(input int sel, output int ih, output int p,
                                output int s, output int ns, output int oh);
        if (sel == 1) begin
            ih = 5; p = 0; s = 2; ns = 2;
        end else begin
            ih = 4; p = 1; s = 1; ns = (sel == 2) ? 1 : 2;
        end
        oh = (ih + 2*p - 3) / s + 1;
    endfunction

    function automatic logic [35:0] exp_beat(int sel, int r, int c, int s);
        int ih, p, st, ns, oh, wr, wc;
        logic pad;
        cfg(sel, ih, p, st, ns, oh);
        wr  = -p + r*st;
        wc  = -p + c*st;
        pad = (wr < 0) || (wc < 0) || (wr + 3 > ih) || (wc + 3 > ih);
        return pack(wr, wc, r*oh + c, s, s == 0, s == ns - 1,
                    (r == oh-1) && (c == oh-1) && (s == ns-1), pad);
    endfunction

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic sweep(input int sel, input bit rnd, input int abort_at,
                         input int rst_at, input bit mid_start);
        int ih, p, st, ns, oh, nf, stalls, total;
        logic [35:0] held, e, o;
        bit hold_pend, ended;
        cfg(sel, ih, p, st, ns, oh);
        q.delete();
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < oh; c++)
                for (int s = 0; s < ns; s++)
                    q.push_back(exp_beat(sel, r, c, s));
        total = q.size();
        nf = 0; stalls = 0; hold_pend = 0; ended = 0;
        st_v[sel] = 1'b1;
        rdy[sel]  = 1'b1;
        @(negedge clk);
        st_v[sel] = 1'b0;
        chk("first_valid", vld[sel], 1);
        chk("first_beat", obs_of(sel), q[0]);
        for (int cyc = 0; cyc < 1000 && !ended; cyc++) begin
            o = obs_of(sel);
            if (hold_pend) chk("hold", o, held);
            hold_pend = 0;
            if (dn[sel]) begin
                chk("done_ctl", {vld[sel], bsy[sel]}, 2'b00);
                chk("beat_count", nf, total);
`ifdef STOCH_IM2COL_SEQ_PERF_EN
                if (rnd && sel == 0) begin
                    chk("beat_cnt", bc[0], 32);
                    chk("stall_cnt", sc[0], stalls);
                end
`endif
                st_v[sel] = 1'b1;
                @(negedge clk);
                st_v[sel] = 1'b0;
                chk("done_start_ign", {vld[sel], bsy[sel], dn[sel]}, 3'b000);
                ended = 1;
            end else begin
                chk("valid_run", vld[sel], 1);
                rdy[sel]  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                st_v[sel] = mid_start && nf == 5;
                if (nf == abort_at) begin
                    ab[sel] = 1'b1;
                    @(negedge clk);
                    ab[sel] = 1'b0;
                    chk("abort_ctl", {vld[sel], dn[sel], bsy[sel]}, 3'b000);
                    chk("abort_beat", obs_of(sel), exp_beat(sel, 0, 0, 0));
                    @(negedge clk);
                    chk("abort_no_done", {vld[sel], dn[sel]}, 2'b00);
                    ended = 1;
                end else if (nf == rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_ctl", {vld[sel], dn[sel], bsy[sel]}, 3'b000);
                    chk("rst_beat", obs_of(sel), exp_beat(sel, 0, 0, 0));
`ifdef STOCH_IM2COL_SEQ_PERF_EN
                    chk("rst_perf", {sc[sel], bc[sel]}, 64'd0);
`endif
                    ended = 1;
                end else begin
                    if (rdy[sel]) begin
                        e = q.pop_front();
                        chk("beat", o, e);
                        if (sel == 0 && !rnd && nf == 10)
                            chk("beat10", {o[35:20], o[0]}, 17'h0_0000);
                        if (sel == 0 && !rnd && nf == 31)
                            chk("beat31", {o[19:12], o[35:20], o[1]},
                                {8'd15, 16'h0202, 1'b1});
                        nf++;
                    end else begin
                        held = o;
                        hold_pend = 1;
                        stalls++;
                    end
                    @(negedge clk);
                end
            end
        end
        st_v[sel] = 1'b0;
        if (!ended) chk("timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_v[i] = 1'b0;
            ab[i]   = 1'b0;
            rdy[i]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ctl", {vld[i], dn[i], bsy[i]}, 3'b000);
            chk("reset_beat", obs_of(i), exp_beat(i, 0, 0, 0));
        end
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("idle_abort", {vld[0], bsy[0], dn[0]}, 3'b000);

        sweep(0, 1'b0, -1, -1, 1'b1);
        sweep(0, 1'b0, 7, -1, 1'b0);
        sweep(0, 1'b1, -1, -1, 1'b0);
        sweep(0, 1'b0, -1, 12, 1'b0);
        sweep(1, 1'b0, -1, -1, 1'b0);
        sweep(2, 1'b0, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
